// File: rtl/regfile_read_stage.sv
// Register-file read stage for the pipelined MIPS core.
// Accepts decoded instructions, reads the register file, bypasses the
// same-cycle write-back, forces $zero, and tracks in-flight destination
// writes in a scoreboard so RAW/WAW hazards stall issue. Operands are
// presented registered one cycle after acceptance.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   in_valid/in_ready   decoded-instruction handshake (in_rs, in_rt, in_rd, in_rd_we)
//   rf_ra1/rf_ra2       register-file read addresses (combinational copies of rs/rt)
//   rf_rd1/rf_rd2       register-file read data (combinational read)
//   wb_en/wb_addr/wb_data  write-back port, used for bypass and scoreboard clear
//   out_valid/out_ready operand handshake toward execute (out_rs_data, out_rt_data,
//                       out_rd, out_rd_we)
//   stall_count         saturating count of hazard-stall cycles
module regfile_read_stage #(
  parameter int unsigned N    = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rs,
  input  logic [AW-1:0] in_rt,
  input  logic [AW-1:0] in_rd,
  input  logic          in_rd_we,
  output logic [AW-1:0] rf_ra1,
  output logic [AW-1:0] rf_ra2,
  input  logic [N-1:0]  rf_rd1,
  input  logic [N-1:0]  rf_rd2,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [N-1:0]  wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_rs_data,
  output logic [N-1:0]  out_rt_data,
  output logic [AW-1:0] out_rd,
  output logic          out_rd_we,
  output logic [15:0]   stall_count
);

  localparam int unsigned CW = 16;

  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_n;
  logic [NREG-1:0] wb_clr;
  logic [NREG-1:0] live;
  logic            hazard;
  logic            accept;
  logic [N-1:0]    rs_sel;
  logic [N-1:0]    rt_sel;

  // Operand mux: $zero, then write-back bypass, then register-file data.
  function automatic logic [N-1:0] sel_op(
    input logic [AW-1:0] addr,
    input logic [N-1:0]  rf_data,
    input logic          wen,
    input logic [AW-1:0] waddr,
    input logic [N-1:0]  wdata
  );
    if (addr == '0)                  return '0;
    else if (wen && (waddr == addr)) return wdata;
    else                             return rf_data;
  endfunction

  assign rf_ra1 = in_rs;
  assign rf_ra2 = in_rt;

  // Registers being written back this cycle are no longer a hazard.
  always_comb begin
    wb_clr = '0;
    for (int i = 1; i < int'(NREG); i++) begin
      if (wb_en && (wb_addr == AW'(i))) wb_clr[i] = 1'b1;
    end
  end

  assign live = pend & ~wb_clr;

  // WAW also stalls: only one write per register may be in flight.
  assign hazard = live[in_rs] | live[in_rt] |
                  (in_rd_we & (in_rd != '0) & live[in_rd]);

  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  assign rs_sel = sel_op(in_rs, rf_rd1, wb_en, wb_addr, wb_data);
  assign rt_sel = sel_op(in_rt, rf_rd2, wb_en, wb_addr, wb_data);

  // Next scoreboard: write-back clears first so a same-cycle set wins.
  always_comb begin
    pend_n = pend & ~wb_clr;
    if (accept && in_rd_we && (in_rd != '0)) pend_n[in_rd] = 1'b1;
    pend_n[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend <= '0;
    else      pend <= pend_n;
  end

  // Output register toward execute; holds while backpressured.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_rs_data <= '0;
      out_rt_data <= '0;
      out_rd      <= '0;
      out_rd_we   <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_rs_data <= rs_sel;
      out_rt_data <= rt_sel;
      out_rd      <= in_rd;
      out_rd_we   <= in_rd_we;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  // Hazard-stall counter, saturating; backpressure-only stalls are excluded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (in_valid && hazard && (stall_count != {CW{1'b1}})) begin
      stall_count <= stall_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_regfile_read_stage.sv
// Directed bench for regfile_read_stage with a queue-based scoreboard:
// the driver pushes hand-computed operands on acceptance, a monitor pops
// and compares whenever execute consumes an output.
module tb_regfile_read_stage;

  localparam int unsigned N  = 32;
  localparam int unsigned AW = 5;

  typedef struct {
    logic [N-1:0]  rs_data;
    logic [N-1:0]  rt_data;
    logic [AW-1:0] rd;
    logic          rd_we;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rs;
  logic [AW-1:0] in_rt;
  logic [AW-1:0] in_rd;
  logic          in_rd_we;
  logic [AW-1:0] rf_ra1;
  logic [AW-1:0] rf_ra2;
  logic [N-1:0]  rf_rd1;
  logic [N-1:0]  rf_rd2;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [N-1:0]  wb_data;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_rs_data;
  logic [N-1:0]  out_rt_data;
  logic [AW-1:0] out_rd;
  logic          out_rd_we;
  logic [15:0]   stall_count;

  exp_t sb[$];
  int   applied;
  int   miscompares;

  regfile_read_stage #(.N(N), .NREG(32), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs_data(out_rs_data), .out_rt_data(out_rt_data),
    .out_rd(out_rd), .out_rd_we(out_rd_we),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic [AW-1:0] rd, input logic we,
                       input logic [N-1:0] d1, input logic [N-1:0] d2);
    in_valid = 1'b1;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_rd_we = we;
    rf_rd1   = d1;
    rf_rd2   = d2;
  endtask

  task automatic set_wb(input logic en, input logic [AW-1:0] a, input logic [N-1:0] d);
    wb_en   = en;
    wb_addr = a;
    wb_data = d;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits (bounded) for acceptance of the driven instruction; returns at posedge+1.
  task automatic wait_accept(input string name, input bit push,
                             input logic [N-1:0] ers, input logic [N-1:0] ert,
                             input logic [AW-1:0] erd, input logic ewe);
    exp_t e;
    bit   done;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        check({name, "_ra1"}, 32'(rf_ra1), 32'(in_rs));
        check({name, "_ra2"}, 32'(rf_ra2), 32'(in_rt));
        if (push) begin
          e.rs_data = ers;
          e.rt_data = ert;
          e.rd      = erd;
          e.rd_we   = ewe;
          sb.push_back(e);
        end
        done = 1'b1;
      end
    end
    if (!done) begin
      applied++;
      miscompares++;
      $display("FAIL %s_accept_timeout: in_ready=%0b required 1 within 100 cycles", name, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: compare every consumed output against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          applied++;
          miscompares++;
          $display("FAIL unexpected_output: out_rs_data=0x%0h with empty scoreboard", out_rs_data);
        end else begin
          e = sb.pop_front();
          check("mon_rs_data", out_rs_data, e.rs_data);
          check("mon_rt_data", out_rt_data, e.rt_data);
          check("mon_rd",      32'(out_rd),    32'(e.rd));
          check("mon_rd_we",   32'(out_rd_we), 32'(e.rd_we));
        end
      end
    end
  end

  initial begin
    applied     = 0;
    miscompares = 0;
    rst         = 1'b0;
    in_valid    = 1'b0;
    in_rs       = '0;
    in_rt       = '0;
    in_rd       = '0;
    in_rd_we    = 1'b0;
    rf_rd1      = '0;
    rf_rd2      = '0;
    out_ready   = 1'b1;
    set_wb(1'b0, '0, '0);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid",   32'(out_valid), 32'd0);
    check("rst_out_rs_data", out_rs_data, 32'd0);
    check("rst_out_rd_we",   32'(out_rd_we), 32'd0);
    check("rst_stall_count", 32'(stall_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Basic read, latency 1
    drive(5'd3, 5'd4, 5'd0, 1'b0, 32'h11, 32'h22);
    wait_accept("basic", 1'b1, 32'h11, 32'h22, 5'd0, 1'b0);
    check("basic_latency_valid", 32'(out_valid), 32'd1);
    idle(1);

    // Reset while an output is pending
    out_ready = 1'b0;
    drive(5'd3, 5'd4, 5'd0, 1'b0, 32'h11, 32'h22);
    wait_accept("pre_reset", 1'b0, '0, '0, '0, 1'b0);
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_out_valid",   32'(out_valid), 32'd0);
    check("midrst_out_rs_data", out_rs_data, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;

    // $zero forcing with write-back to register 0
    set_wb(1'b1, 5'd0, 32'h5555);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 32'hDEAD, 32'hDEAD);
    wait_accept("zero", 1'b1, 32'h0, 32'h0, 5'd0, 1'b0);
    set_wb(1'b0, '0, '0);

    // RAW stall on r5, released by write-back bypass
    drive(5'd1, 5'd2, 5'd5, 1'b1, 32'h11, 32'h22);
    wait_accept("raw_prod", 1'b1, 32'h11, 32'h22, 5'd5, 1'b1);
    drive(5'd5, 5'd0, 5'd0, 1'b0, 32'h9999, 32'h8888);
    @(negedge clk);
    check("raw_in_ready", 32'(in_ready), 32'd0);
    check("raw_stall0",   32'(stall_count), 32'd0);
    repeat (3) @(negedge clk);
    check("raw_stall3",   32'(stall_count), 32'd3);
    @(posedge clk);
    #1;
    set_wb(1'b1, 5'd5, 32'hABCD);
    wait_accept("raw_bypass", 1'b1, 32'hABCD, 32'h0, 5'd0, 1'b0);
    set_wb(1'b0, '0, '0);
    check("raw_stall_final", 32'(stall_count), 32'd4);
    drive(5'd5, 5'd5, 5'd0, 1'b0, 32'h31, 32'h32);
    #1;
    check("r5_cleared_ready", 32'(in_ready), 32'd1);
    wait_accept("r5_cleared", 1'b1, 32'h31, 32'h32, 5'd0, 1'b0);

    // WAW stall on r7; set wins over same-cycle clear
    drive(5'd0, 5'd0, 5'd7, 1'b1, 32'h1, 32'h2);
    wait_accept("waw_first", 1'b1, 32'h0, 32'h0, 5'd7, 1'b1);
    drive(5'd1, 5'd2, 5'd7, 1'b1, 32'h41, 32'h42);
    @(negedge clk);
    check("waw_in_ready0", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    check("waw_in_ready2", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    set_wb(1'b1, 5'd7, 32'h7777);
    wait_accept("waw_second", 1'b1, 32'h41, 32'h42, 5'd7, 1'b1);
    set_wb(1'b0, '0, '0);
    drive(5'd7, 5'd0, 5'd0, 1'b0, 32'h5, 32'h6);
    @(negedge clk);
    check("r7_still_pend", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    set_wb(1'b1, 5'd7, 32'h77AA);
    wait_accept("r7_bypass", 1'b1, 32'h77AA, 32'h0, 5'd0, 1'b0);
    set_wb(1'b0, '0, '0);
    check("waw_stall_count", 32'(stall_count), 32'd8);
    idle(1);

    // Backpressure: hold for 10 cycles, then drain and accept together
    out_ready = 1'b0;
    drive(5'd1, 5'd2, 5'd3, 1'b0, 32'h51, 32'h52);
    wait_accept("bp_a", 1'b1, 32'h51, 32'h52, 5'd3, 1'b0);
    drive(5'd6, 5'd8, 5'd0, 1'b0, 32'h61, 32'h62);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_in_ready",  32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_rs_hold",   out_rs_data, 32'h51);
      check("bp_rt_hold",   out_rt_data, 32'h52);
    end
    check("bp_stall_count", 32'(stall_count), 32'd8);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_accept("bp_b", 1'b1, 32'h61, 32'h62, 5'd0, 1'b0);
    check("bp_b_valid", 32'(out_valid), 32'd1);
    check("bp_b_rs",    out_rs_data, 32'h61);

    // Saturation of stall_count
    drive(5'd0, 5'd0, 5'd9, 1'b1, 32'h1, 32'h2);
    wait_accept("sat_prod", 1'b1, 32'h0, 32'h0, 5'd9, 1'b1);
    drive(5'd9, 5'd0, 5'd0, 1'b0, 32'h3, 32'h4);
    repeat (70000) @(posedge clk);
    @(negedge clk);
    check("sat_in_ready",    32'(in_ready), 32'd0);
    check("sat_stall_count", 32'(stall_count), 32'hFFFF);
    @(posedge clk);
    #1;
    set_wb(1'b1, 5'd9, 32'h9090);
    wait_accept("sat_release", 1'b1, 32'h9090, 32'h0, 5'd0, 1'b0);
    set_wb(1'b0, '0, '0);
    check("sat_hold", 32'(stall_count), 32'hFFFF);

    idle(4);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_read_stage.md
Name: regfile_read_stage

Overview:
- Read side of the register file for the pipelined MIPS core.
- Accepts decoded instructions (rs, rt, rd) on a valid/ready handshake and drives the register-file read addresses.
- Applies write-back bypass and $zero forcing, tracks in-flight destination writes in a scoreboard, and stalls on RAW/WAW hazards.
- Presents registered operands to the execute stage one cycle after acceptance.

Parameters:
- N, 32, data width of one register.
- NREG, 32, number of architectural registers.
- AW, 5, register address width; must satisfy 2**AW >= NREG.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-low
- in_valid  input  1  decoded instruction present
- in_ready  output  1  stage accepts the instruction this cycle
- in_rs  input  AW  source register 1 address
- in_rt  input  AW  source register 2 address
- in_rd  input  AW  destination register address
- in_rd_we  input  1  instruction will write in_rd
- rf_ra1  output  AW  register-file read address 1; combinational copy of in_rs
- rf_ra2  output  AW  register-file read address 2; combinational copy of in_rt
- rf_rd1  input  N  register-file read data 1 (combinational read)
- rf_rd2  input  N  register-file read data 2
- wb_en  input  1  write-back this cycle
- wb_addr  input  AW  write-back register
- wb_data  input  N  write-back data
- out_valid  output  1  operands valid toward execute
- out_ready  input  1  execute consumes operands
- out_rs_data  output  N  operand 1
- out_rt_data  output  N  operand 2
- out_rd  output  AW  destination register, passed through
- out_rd_we  output  1  destination write enable, passed through
- stall_count  output  16  saturating count of hazard-stall cycles

Behaviour:
- Reset (rst=0, asynchronous):
  - out_valid=0; out_rs_data, out_rt_data, out_rd, out_rd_we = 0.
  - All scoreboard pending bits = 0; stall_count=0.
  - Reset mid-operation discards the output entry and all pending state.
- Scoreboard:
  - pend[NREG-1:0]; pend[0] is always 0.
  - Write-back clears: wb_en with wb_addr!=0 clears pend[wb_addr] at the clock edge.
  - Acceptance sets: an accepted instruction with in_rd_we=1 and in_rd!=0 sets pend[in_rd].
  - If the same register is set and cleared in the same cycle, set wins.
  - wb_en to register 0 is ignored.
- Hazard (combinational):
  - Define live(r) = pend[r] && !(wb_en && wb_addr==r && r!=0).
  - hazard = live(in_rs) || live(in_rt) || (in_rd_we && in_rd!=0 && live(in_rd)).
  - Only one in-flight write per register is permitted, so WAW stalls.
- Handshake:
  - in_ready = (!out_valid || out_ready) && !hazard.
  - Accept = in_valid && in_ready.
  - in_ready may depend on in_* inputs. The upstream stage must hold its inputs stable while in_valid=1 and in_ready=0.
- Operand select (at accept), for each of rs and rt:
  - address 0 -> 0;
  - else if wb_en && wb_addr==addr -> wb_data (bypass);
  - else rf_rd1 / rf_rd2.
- Output register:
  - Latency is 1 cycle from accept to out_valid=1.
  - While out_valid && !out_ready, all out_* hold stable.
  - Accept loads new contents and sets out_valid=1.
  - out_ready && no accept clears out_valid.
  - A simultaneous drain and accept gives back-to-back throughput of 1 per cycle.
- stall_count:
  - Increments when in_valid && hazard.
  - Saturates at 16'hFFFF.
  - Does not count backpressure-only stalls (out_valid && !out_ready && !hazard).

Test Plan:
- Reset, then drive in_valid with rs=3, rt=4, rf_rd1=0x11, rf_rd2=0x22, out_ready=1 -> next cycle out_valid=1, out_rs_data=0x11, out_rt_data=0x22; asserting rst mid-stream -> out_valid=0 immediately.
- rs=0, rt=0 with rf_rd1=rf_rd2=0xDEAD, plus a same-cycle wb_en to register 0 -> both operands 0; pend unchanged.
- Issue rd=5 with rd_we=1, then issue rs=5 -> in_ready=0 and stall_count increments each cycle. Then wb_en, wb_addr=5, wb_data=0xABCD -> accepted that same cycle with out_rs_data=0xABCD (bypass), and pend[5] cleared.
- Issue rd=7 with rd_we, then a second instruction with rd=7 -> WAW stall until write-back to 7. In the write-back cycle the second instruction is accepted and pend[7] ends set.
- Hold out_ready=0 with a valid output -> in_ready=0, out_* stable for 10 cycles, stall_count unchanged. Release out_ready -> drain and accept occur in the same cycle.
- Force a hazard for 70000 cycles -> stall_count saturates at 0xFFFF.
